// File: rtl/vga_mode_pkg.sv
// Shared types, register map and the per-mode timing programme for vga_mode_seq.
// Each table row is the full 10-write sequence: disable, eight timing registers, enable.
package vga_mode_pkg;

    localparam int MODE_COUNT = 4;
    localparam int SEQ_LEN    = 10;
    localparam logic [3:0] LAST_IDX = 4'd9;

    localparam logic [11:0] REG_CTRL   = 12'h000;
    localparam logic [11:0] REG_H_ACT  = 12'h010;
    localparam logic [11:0] REG_H_FP   = 12'h014;
    localparam logic [11:0] REG_H_SYNC = 12'h018;
    localparam logic [11:0] REG_H_BP   = 12'h01C;
    localparam logic [11:0] REG_V_ACT  = 12'h020;
    localparam logic [11:0] REG_V_FP   = 12'h024;
    localparam logic [11:0] REG_V_SYNC = 12'h028;
    localparam logic [11:0] REG_V_BP   = 12'h02C;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RESP     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_READBACK = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WRESP, S_RD, S_RDATA, S_NEXT, S_DONE, S_ERR
    } seq_state_t;

    typedef enum logic [1:0] {P_IDLE, P_ADDR, P_RESP} wr_phase_t;

    typedef struct packed {
        logic [15:0] h_act, h_fp, h_sync, h_bp, v_act, v_fp, v_sync, v_bp;
    } timing_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } reg_wr_t;

    typedef reg_wr_t [SEQ_LEN-1:0] mode_row_t;
    typedef mode_row_t [MODE_COUNT-1:0] mode_table_t;

    localparam timing_t T_640X480  = '{16'd640,  16'd16,  16'd96,  16'd48,  16'd480, 16'd10, 16'd2, 16'd33};
    localparam timing_t T_800X600  = '{16'd800,  16'd40,  16'd128, 16'd88,  16'd600, 16'd1,  16'd4, 16'd23};
    localparam timing_t T_1024X768 = '{16'd1024, 16'd24,  16'd136, 16'd160, 16'd768, 16'd3,  16'd6, 16'd29};
    localparam timing_t T_1280X720 = '{16'd1280, 16'd110, 16'd40,  16'd220, 16'd720, 16'd5,  16'd5, 16'd20};

    function automatic mode_row_t build_row(input timing_t t);
        mode_row_t r;
        r[0] = '{REG_CTRL,   32'd0};
        r[1] = '{REG_H_ACT,  {16'd0, t.h_act}};
        r[2] = '{REG_H_FP,   {16'd0, t.h_fp}};
        r[3] = '{REG_H_SYNC, {16'd0, t.h_sync}};
        r[4] = '{REG_H_BP,   {16'd0, t.h_bp}};
        r[5] = '{REG_V_ACT,  {16'd0, t.v_act}};
        r[6] = '{REG_V_FP,   {16'd0, t.v_fp}};
        r[7] = '{REG_V_SYNC, {16'd0, t.v_sync}};
        r[8] = '{REG_V_BP,   {16'd0, t.v_bp}};
        r[9] = '{REG_CTRL,   32'd1};
        return r;
    endfunction

    // Element [0] is mode 0 (least significant slice of the packed table).
    localparam mode_table_t MODE_TABLE = {build_row(T_1280X720), build_row(T_1024X768),
                                          build_row(T_800X600),  build_row(T_640X480)};

endpackage

// File: rtl/vga_axil_wr_single.sv
// One AXI4-Lite write: AW and W raised together and released independently, then B.
// A handshake that stalls for TIMEOUT cycles in either phase aborts and drops every valid/ready.
module vga_axil_wr_single
    import vga_mode_pkg::*;
#(
    parameter int TIMEOUT = 1024
)
(
    input  logic        aclk,
    input  logic        areset,
    input  logic        start,
    input  logic [11:0] addr,
    input  logic [31:0] data,
    output logic        accepted,
    output logic        resp_ok,
    output logic        resp_err,
    output logic        timeout,
    output logic [11:0] ctrl_awaddr,
    output logic        ctrl_awvalid,
    input  logic        ctrl_awready,
    output logic [31:0] ctrl_wdata,
    output logic [3:0]  ctrl_wstrb,
    output logic        ctrl_wvalid,
    input  logic        ctrl_wready,
    input  logic [1:0]  ctrl_bresp,
    input  logic        ctrl_bvalid,
    output logic        ctrl_bready
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    wr_phase_t     phase_reg;
    logic [CW-1:0] cnt_reg;
    logic          awvalid_reg, wvalid_reg, bready_reg;
    logic [11:0]   awaddr_reg;
    logic [31:0]   wdata_reg;
    logic          aw_pend, w_pend;

    always_comb begin
        aw_pend  = awvalid_reg && !ctrl_awready;
        w_pend   = wvalid_reg && !ctrl_wready;
        accepted = (phase_reg == P_ADDR) && !aw_pend && !w_pend;
        resp_ok  = (phase_reg == P_RESP) && ctrl_bvalid && (ctrl_bresp == 2'b00);
        resp_err = (phase_reg == P_RESP) && ctrl_bvalid && (ctrl_bresp != 2'b00);
        // A handshake completing on the last allowed cycle still wins over the abort.
        timeout  = (cnt_reg == CNT_MAX) &&
                   (((phase_reg == P_ADDR) && !accepted) || ((phase_reg == P_RESP) && !ctrl_bvalid));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            phase_reg   <= P_IDLE;
            cnt_reg     <= '0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
        end else begin
            case (phase_reg)
                P_IDLE: if (start) begin
                    phase_reg   <= P_ADDR;
                    awvalid_reg <= 1'b1;
                    wvalid_reg  <= 1'b1;
                    awaddr_reg  <= addr;
                    wdata_reg   <= data;
                    cnt_reg     <= '0;
                end
                P_ADDR: begin
                    awvalid_reg <= aw_pend;
                    wvalid_reg  <= w_pend;
                    if (accepted) begin
                        phase_reg  <= P_RESP;
                        bready_reg <= 1'b1;
                        cnt_reg    <= '0;
                    end else if (timeout) begin
                        phase_reg   <= P_IDLE;
                        awvalid_reg <= 1'b0;
                        wvalid_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                P_RESP: begin
                    if (ctrl_bvalid || timeout) begin
                        phase_reg  <= P_IDLE;
                        bready_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: phase_reg <= P_IDLE;
            endcase
        end
    end

    assign ctrl_awaddr  = awaddr_reg;
    assign ctrl_awvalid = awvalid_reg;
    assign ctrl_wdata   = wdata_reg;
    assign ctrl_wstrb   = 4'hF;
    assign ctrl_wvalid  = wvalid_reg;
    assign ctrl_bready  = bready_reg;

endmodule

// File: rtl/vga_mode_seq.sv
// Reprograms the vga timing registers from the mode table: disable, 8 timing writes, enable.
// Optional readback-verify of each write is enabled by defining VGA_MODE_SEQ_READBACK_EN.
module vga_mode_seq
    import vga_mode_pkg::*;
#(
    parameter int NUM_MODES = MODE_COUNT,
    parameter int TIMEOUT   = 1024
)
(
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [$clog2(NUM_MODES)-1:0] req_mode,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic [11:0]                  ctrl_awaddr,
    output logic                         ctrl_awvalid,
    input  logic                         ctrl_awready,
    output logic [31:0]                  ctrl_wdata,
    output logic [3:0]                   ctrl_wstrb,
    output logic                         ctrl_wvalid,
    input  logic                         ctrl_wready,
    input  logic [1:0]                   ctrl_bresp,
    input  logic                         ctrl_bvalid,
    output logic                         ctrl_bready,
    output logic [11:0]                  ctrl_araddr,
    output logic                         ctrl_arvalid,
    input  logic                         ctrl_arready,
    input  logic [31:0]                  ctrl_rdata,
    input  logic [1:0]                   ctrl_rresp,
    input  logic                         ctrl_rvalid,
    output logic                         ctrl_rready
);
    seq_state_t                   state_reg, state_next;
    logic [$clog2(NUM_MODES)-1:0] mode_reg, tbl_mode;
    logic [3:0]                   idx_reg, tbl_idx;
    logic [1:0]                   err_code_reg, err_code_next;
    logic                         wr_start, wr_accepted, wr_resp_ok, wr_resp_err, wr_timeout;
    reg_wr_t                      wr_entry, cur_entry;

    // In IDLE the lookup uses the incoming request so the first write launches on the accept edge.
    always_comb begin
        tbl_mode = (state_reg == S_IDLE) ? req_mode : mode_reg;
        tbl_idx  = idx_reg;
        if (state_reg == S_IDLE)
            tbl_idx = 4'd0;
        else if (state_reg == S_NEXT && idx_reg != LAST_IDX)
            tbl_idx = idx_reg + 4'd1;
    end

    assign wr_entry  = MODE_TABLE[tbl_mode][tbl_idx];
    assign cur_entry = MODE_TABLE[mode_reg][idx_reg];

`ifdef VGA_MODE_SEQ_READBACK_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] RD_CNT_MAX = CW'(TIMEOUT - 1);
    logic [CW-1:0] rd_cnt_reg;
    logic          rd_timeout;

    assign rd_timeout = (rd_cnt_reg == RD_CNT_MAX);

    always_ff @(posedge aclk) begin
        if (areset || state_next != state_reg)
            rd_cnt_reg <= '0;
        else
            rd_cnt_reg <= rd_cnt_reg + 1'b1;
    end

    assign ctrl_arvalid = (state_reg == S_RD);
    assign ctrl_araddr  = cur_entry.addr;
    assign ctrl_rready  = (state_reg == S_RDATA);
`else
    logic unused_rd;
    assign unused_rd    = ^{ctrl_arready, ctrl_rdata, ctrl_rresp, ctrl_rvalid};
    assign ctrl_arvalid = 1'b0;
    assign ctrl_araddr  = 12'h000;
    assign ctrl_rready  = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        err_code_next = err_code_reg;
        wr_start      = 1'b0;
        case (state_reg)
            S_IDLE: if (req_valid) begin
                state_next    = S_WR;
                err_code_next = ERR_NONE;
                wr_start      = 1'b1;
            end
            S_WR: begin
                if (wr_accepted) state_next = S_WRESP;
                else if (wr_timeout) begin
                    state_next    = S_ERR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            S_WRESP: begin
                if (wr_resp_err) begin
                    state_next    = S_ERR;
                    err_code_next = ERR_RESP;
                end else if (wr_resp_ok) begin
`ifdef VGA_MODE_SEQ_READBACK_EN
                    state_next = (idx_reg == LAST_IDX) ? S_NEXT : S_RD;
`else
                    state_next = S_NEXT;
`endif
                end else if (wr_timeout) begin
                    state_next    = S_ERR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
`ifdef VGA_MODE_SEQ_READBACK_EN
            S_RD: begin
                if (ctrl_arready) state_next = S_RDATA;
                else if (rd_timeout) begin
                    state_next    = S_ERR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            S_RDATA: begin
                if (ctrl_rvalid) begin
                    if (ctrl_rresp != 2'b00) begin
                        state_next    = S_ERR;
                        err_code_next = ERR_RESP;
                    end else if (ctrl_rdata != cur_entry.data) begin
                        state_next    = S_ERR;
                        err_code_next = ERR_READBACK;
                    end else begin
                        state_next = S_NEXT;
                    end
                end else if (rd_timeout) begin
                    state_next    = S_ERR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
`endif
            S_NEXT: begin
                if (idx_reg == LAST_IDX) state_next = S_DONE;
                else begin
                    state_next = S_WR;
                    wr_start   = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg    <= S_IDLE;
            mode_reg     <= '0;
            idx_reg      <= '0;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            err_code_reg <= err_code_next;
            if (state_reg == S_IDLE && req_valid) begin
                mode_reg <= req_mode;
                idx_reg  <= 4'd0;
            end else if (state_reg == S_NEXT) begin
                idx_reg <= tbl_idx;
            end
        end
    end

    vga_axil_wr_single #(.TIMEOUT(TIMEOUT)) u_wr (
        .aclk         (aclk),
        .areset       (areset),
        .start        (wr_start),
        .addr         (wr_entry.addr),
        .data         (wr_entry.data),
        .accepted     (wr_accepted),
        .resp_ok      (wr_resp_ok),
        .resp_err     (wr_resp_err),
        .timeout      (wr_timeout),
        .ctrl_awaddr  (ctrl_awaddr),
        .ctrl_awvalid (ctrl_awvalid),
        .ctrl_awready (ctrl_awready),
        .ctrl_wdata   (ctrl_wdata),
        .ctrl_wstrb   (ctrl_wstrb),
        .ctrl_wvalid  (ctrl_wvalid),
        .ctrl_wready  (ctrl_wready),
        .ctrl_bresp   (ctrl_bresp),
        .ctrl_bvalid  (ctrl_bvalid),
        .ctrl_bready  (ctrl_bready)
    );

    assign req_ready = (state_reg == S_IDLE);
    assign busy      = !(state_reg inside {S_IDLE, S_DONE, S_ERR});
    assign done      = (state_reg == S_DONE);
    assign err       = (state_reg == S_ERR);
    assign err_code  = err_code_reg;

endmodule

// File: tb/tb_vga_mode_seq.sv
// Directed bench for vga_mode_seq with a reactive AXI4-Lite slave model driven on the falling edge.
// Covers full sequences, split AW/W acceptance, error response, timeout, ignored request and mid-run reset.
module tb_vga_mode_seq;
    localparam int TIMEOUT = 16;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_mode = 2'd0;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [11:0] ctrl_awaddr, ctrl_araddr;
    logic        ctrl_awvalid, ctrl_wvalid, ctrl_bready, ctrl_arvalid, ctrl_rready;
    logic [31:0] ctrl_wdata;
    logic [3:0]  ctrl_wstrb;
    logic        ctrl_awready = 1'b0, ctrl_wready = 1'b0, ctrl_bvalid = 1'b0;
    logic        ctrl_arready = 1'b0, ctrl_rvalid = 1'b0;
    logic [1:0]  ctrl_bresp = 2'b00, ctrl_rresp = 2'b00;
    logic [31:0] ctrl_rdata = 32'h0;

    always #5 aclk = ~aclk;

    vga_mode_seq #(.TIMEOUT(TIMEOUT)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .ctrl_awaddr(ctrl_awaddr), .ctrl_awvalid(ctrl_awvalid), .ctrl_awready(ctrl_awready),
        .ctrl_wdata(ctrl_wdata), .ctrl_wstrb(ctrl_wstrb), .ctrl_wvalid(ctrl_wvalid), .ctrl_wready(ctrl_wready),
        .ctrl_bresp(ctrl_bresp), .ctrl_bvalid(ctrl_bvalid), .ctrl_bready(ctrl_bready),
        .ctrl_araddr(ctrl_araddr), .ctrl_arvalid(ctrl_arvalid), .ctrl_arready(ctrl_arready),
        .ctrl_rdata(ctrl_rdata), .ctrl_rresp(ctrl_rresp), .ctrl_rvalid(ctrl_rvalid), .ctrl_rready(ctrl_rready)
    );

    // Hand-computed programme: address per step, data per mode and step.
    int exp_addr [10] = '{'h000, 'h010, 'h014, 'h018, 'h01C, 'h020, 'h024, 'h028, 'h02C, 'h000};
    int exp_data [4][10] = '{
        '{0, 640,  16,  96,  48,  480, 10, 2, 33, 1},
        '{0, 800,  40,  128, 88,  600, 1,  4, 23, 1},
        '{0, 1024, 24,  136, 160, 768, 3,  6, 29, 1},
        '{0, 1280, 110, 40,  220, 720, 5,  5, 20, 1}
    };

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
    int          bresp_err_idx = -1;
    bit          rd_corrupt = 1'b0;
    bit          clr_req = 1'b0;
    bit          seen_aw_only = 1'b0;
    logic [11:0] aw_q [$];
    logic [31:0] w_q [$];
    int          b_cnt = 0, ar_cnt = 0, ar_total = 0;
    bit          r_pend = 1'b0;
    logic [11:0] ar_addr = 12'h0;
    logic [31:0] mem [0:1023];

    initial begin
        forever begin
            @(negedge aclk);
            if (areset || clr_req) begin
                aw_q.delete(); w_q.delete();
                b_cnt = 0; ar_cnt = 0; r_pend = 1'b0; aw_wait = 0; w_wait = 0; seen_aw_only = 1'b0;
                for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
                ctrl_awready = 1'b0; ctrl_wready = 1'b0; ctrl_bvalid = 1'b0;
                ctrl_arready = 1'b0; ctrl_rvalid = 1'b0;
            end else begin
                if (ctrl_awvalid && !ctrl_wvalid) seen_aw_only = 1'b1;
                // B and R are decided from handshakes already completed.
                if ((aw_q.size() < w_q.size() ? aw_q.size() : w_q.size()) > b_cnt) begin
                    ctrl_bvalid = 1'b1;
                    ctrl_bresp  = (b_cnt == bresp_err_idx) ? 2'b10 : 2'b00;
                    mem[aw_q[b_cnt][11:2]] = w_q[b_cnt];
                    if (ctrl_bready) begin
                        $display("WR %0d addr=0x%03h data=0x%08h bresp=%0d", b_cnt, aw_q[b_cnt], w_q[b_cnt], ctrl_bresp);
                        b_cnt++;
                    end
                end else begin
                    ctrl_bvalid = 1'b0;
                end
                if (r_pend) begin
                    ctrl_rvalid = 1'b1;
                    ctrl_rresp  = 2'b00;
                    ctrl_rdata  = (rd_corrupt && ar_addr == 12'h010) ? 32'h0 : mem[ar_addr[11:2]];
                    if (ctrl_rready) begin
                        $display("RD addr=0x%03h data=0x%08h", ar_addr, ctrl_rdata);
                        r_pend = 1'b0;
                    end
                end else begin
                    ctrl_rvalid = 1'b0;
                end
                if (ctrl_awvalid) begin
                    if (aw_wait >= aw_delay) begin
                        ctrl_awready = 1'b1; aw_q.push_back(ctrl_awaddr); aw_wait = 0;
                    end else begin
                        ctrl_awready = 1'b0; aw_wait++;
                    end
                end else begin
                    ctrl_awready = 1'b0; aw_wait = 0;
                end
                if (ctrl_wvalid) begin
                    if (w_wait >= w_delay) begin
                        ctrl_wready = 1'b1; w_q.push_back(ctrl_wdata); w_wait = 0;
                    end else begin
                        ctrl_wready = 1'b0; w_wait++;
                    end
                end else begin
                    ctrl_wready = 1'b0; w_wait = 0;
                end
                if (ctrl_arvalid && !r_pend) begin
                    ctrl_arready = 1'b1; ar_addr = ctrl_araddr; r_pend = 1'b1; ar_cnt++; ar_total++;
                end else begin
                    ctrl_arready = 1'b0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    task automatic clear_slave();
        @(posedge aclk);
        clr_req = 1'b1;
        @(negedge aclk);
        #1;
        clr_req = 1'b0;
    endtask

    task automatic send_req(input logic [1:0] m);
        req_mode  = m;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit got_done, output bit got_err, output int awv);
        got_done = 1'b0; got_err = 1'b0; awv = 0;
        for (int c = 0; c < budget; c++) begin
            if (done || err) begin
                got_done = done; got_err = err;
                return;
            end
            if (ctrl_awvalid) awv++;
            tick();
        end
        check("wait_budget", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit d, e;
        int awv;

        // ---- reset values ----
        repeat (3) tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_awvalid", ctrl_awvalid, 0);
        check("rst_wvalid", ctrl_wvalid, 0);
        check("rst_bready", ctrl_bready, 0);
        check("rst_arvalid", ctrl_arvalid, 0);
        check("rst_rready", ctrl_rready, 0);
        check("rst_wstrb", ctrl_wstrb, 4'hF);
        areset = 1'b0;
        tick();

        // ---- 1: mode 0, always-ready slave ----
        send_req(2'd0);
        check("t1_busy", busy, 1);
        check("t1_req_ready_busy", req_ready, 0);
        wait_end(400, d, e, awv);
        check("t1_done", d, 1);
        check("t1_err", e, 0);
        check("t1_busy_at_done", busy, 0);
        check("t1_err_code", err_code, 0);
        check("t1_nwrites", aw_q.size(), 10);
        check("t1_nresp", b_cnt, 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t1_addr%0d", i), aw_q[i], exp_addr[i]);
            check($sformatf("t1_data%0d", i), w_q[i], exp_data[0][i]);
        end
`ifdef VGA_MODE_SEQ_READBACK_EN
        check("t1_nreads", ar_cnt, 9);
`else
        check("t1_nreads", ar_cnt, 0);
`endif
        tick();
        check("t1_req_ready_after", req_ready, 1);
        check("t1_done_single", done, 0);

        // ---- 2: AW accepted 3 cycles late, W immediately ----
        clear_slave();
        aw_delay = 3;
        send_req(2'd1);
        wait_end(600, d, e, awv);
        aw_delay = 0;
        check("t2_done", d, 1);
        check("t2_aw_held_w_dropped", seen_aw_only, 1);
        check("t2_nwrites", aw_q.size(), 10);
        check("t2_nresp", b_cnt, 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t2_addr%0d", i), aw_q[i], exp_addr[i]);
            check($sformatf("t2_data%0d", i), w_q[i], exp_data[1][i]);
        end

        // ---- 3: SLVERR on step 3 ----
        clear_slave();
        bresp_err_idx = 3;
        send_req(2'd2);
        wait_end(400, d, e, awv);
        check("t3_err", e, 1);
        check("t3_done", d, 0);
        check("t3_err_code", err_code, 1);
        check("t3_busy", busy, 0);
        check("t3_req_ready_err_cycle", req_ready, 0);
        tick();
        check("t3_req_ready_next", req_ready, 1);
        check("t3_err_single", err, 0);
        repeat (5) tick();
        bresp_err_idx = -1;
        check("t3_no_more_aw", aw_q.size(), 4);
        check("t3_data3", w_q[3], exp_data[2][3]);
        check("t3_code_held", err_code, 1);

        // ---- 4: AWREADY stuck low -> timeout ----
        clear_slave();
        aw_delay = 1_000_000;
        send_req(2'd0);
        wait_end(200, d, e, awv);
        check("t4_err", e, 1);
        check("t4_err_code", err_code, 2);
        check("t4_wr_cycles", awv, 16);
        check("t4_awvalid_dropped", ctrl_awvalid, 0);
        check("t4_wvalid_dropped", ctrl_wvalid, 0);
        tick();
        aw_delay = 0;
        check("t4_req_ready", req_ready, 1);

        // ---- 5: request while busy is ignored, then reset mid-WR ----
        clear_slave();
        aw_delay = 2;
        send_req(2'd3);
        req_mode  = 2'd1;
        req_valid = 1'b1;
        check("t5_req_ready_busy", req_ready, 0);
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 200 && !(aw_q.size() >= 2 && ctrl_awvalid); c++) tick();
        check("t5_mid_wr", ctrl_awvalid, 1);
        check("t5_mode_kept", w_q[1], exp_data[3][1]);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        aw_delay = 0;
        check("t5_awvalid", ctrl_awvalid, 0);
        check("t5_wvalid", ctrl_wvalid, 0);
        check("t5_bready", ctrl_bready, 0);
        check("t5_busy", busy, 0);
        check("t5_req_ready", req_ready, 1);
        repeat (10) tick();
        check("t5_no_queued_req", aw_q.size(), 0);
        check("t5_still_idle", req_ready, 1);

        // ---- 6: readback ----
`ifdef VGA_MODE_SEQ_READBACK_EN
        clear_slave();
        rd_corrupt = 1'b1;
        send_req(2'd0);
        wait_end(400, d, e, awv);
        rd_corrupt = 1'b0;
        check("t6_err", e, 1);
        check("t6_err_code", err_code, 3);
        check("t6_nwrites", aw_q.size(), 2);
        check("t6_nreads", ar_cnt, 2);
`else
        check("t6_no_ar_traffic", ar_total, 0);
        check("t6_arvalid", ctrl_arvalid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
